dout_packer: RTL and testbench

- Downstream stage of the byte-stream engine. It pulls 8-bit bytes from the engine's dout method and packs them little-endian into 32-bit words.
- Frames are delimited by a programmed byte length. Each frame ends with a last-flagged word carrying a byte-keep mask.
- An internal word FIFO decouples the consumer (bus/DMA side) from the byte source.

---
 rtl/dout_packer_pkg.sv | 33 +++
 rtl/dout_packer_fifo.sv | 49 ++++
 rtl/dout_packer.sv | 157 +++++++++++++++
 tb/tb_dout_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dout_packer_pkg.sv
// Shared types and constants for the dout_packer byte-to-word packer.
// Optional checksum trailer is enabled with DOUT_PACKER_CHECKSUM_EN.
package dout_packer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        CSUM = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 8;
    localparam int REM_W      = 9;

    typedef struct packed {
        logic [8*WORD_BYTES-1:0] value;
        logic [WORD_BYTES-1:0]   keep;
        logic                    last;
    } fifo_entry_t;

    // Keep mask covering lanes 0 up to and including the given lane.
    function automatic logic [WORD_BYTES-1:0] keepMask(input logic [1:0] lane);
        logic [WORD_BYTES-1:0] mask;
        case (lane)
            2'd0:    mask = 4'h1;
            2'd1:    mask = 4'h3;
            2'd2:    mask = 4'h7;
            default: mask = 4'hF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dout_packer_fifo.sv
// Small synchronous word FIFO holding packed words with keep/last sideband.
// Head entry is combinational and reads as zero while the FIFO is empty.
module packer_fifo
    import dout_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  fifo_entry_t wdata_i,
    input  logic        pop_i,
    output fifo_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW:0]   wrPtr_q;
    logic [AW:0]   rdPtr_q;
    logic          doPush;
    logic          doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign head_o  = empty_o ? '0 : mem[rdPtr_q[AW-1:0]];

    // Pointer update; push and pop in the same cycle both take effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care until written since head is masked when empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/dout_packer.sv
// Packs upstream bytes little-endian into 32-bit words framed by a programmed length.
// Define DOUT_PACKER_CHECKSUM_EN to append a 32-bit byte-sum word after each frame.
module dout_packer
    import dout_packer_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [LEN_W-1:0]        in_value,
    input  logic                    in_rdy,
    output logic                    in_en,
    input  logic [LEN_W-1:0]        len_value,
    input  logic                    len_en,
    output logic                    len_rdy,
    output logic [8*WORD_BYTES-1:0] out_value,
    output logic [WORD_BYTES-1:0]   out_keep,
    output logic                    out_last,
    output logic                    out_rdy,
    input  logic                    out_en,
    output logic                    busy
);

    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [REM_W-1:0]        rem_q, rem_d;
    logic [8*WORD_BYTES-1:0] pack_q, pack_d;
`ifdef DOUT_PACKER_CHECKSUM_EN
    logic [31:0]             acc_q, acc_d;
`endif

    logic                    fifoFull;
    logic                    fifoEmpty;
    logic                    fifoPush;
    fifo_entry_t             pushEntry;
    fifo_entry_t             headEntry;
    logic [8*WORD_BYTES-1:0] byteShifted;
    logic                    lastByte;
    logic                    wordDone;

    assign in_en       = (state_q == PACK) & in_rdy & ~fifoFull;
    assign byteShifted = {24'b0, in_value} << {lane_q, 3'b000};
    assign lastByte    = (rem_q == 9'd1);
    assign wordDone    = in_en & ((lane_q == 2'd3) | lastByte);

    // Next-state logic: frame setup, byte packing, word completion and optional trailer.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        rem_d     = rem_q;
        pack_d    = pack_q;
        fifoPush  = 1'b0;
        pushEntry = '0;
`ifdef DOUT_PACKER_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (len_en) begin
                    rem_d   = (len_value == '0) ? 9'd256 : {1'b0, len_value};
                    lane_d  = 2'd0;
                    pack_d  = '0;
                    state_d = PACK;
`ifdef DOUT_PACKER_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            PACK: begin
                if (in_en) begin
                    rem_d = rem_q - 9'd1;
`ifdef DOUT_PACKER_CHECKSUM_EN
                    acc_d = acc_q + {24'b0, in_value};
`endif
                    if (wordDone) begin
                        fifoPush        = 1'b1;
                        pushEntry.value = pack_q | byteShifted;
                        pushEntry.keep  = keepMask(lane_q);
`ifdef DOUT_PACKER_CHECKSUM_EN
                        pushEntry.last  = 1'b0;
`else
                        pushEntry.last  = lastByte;
`endif
                        lane_d = 2'd0;
                        pack_d = '0;
                        if (lastByte) begin
`ifdef DOUT_PACKER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = IDLE;
`endif
                        end
                    end else begin
                        lane_d = lane_q + 2'd1;
                        pack_d = pack_q | byteShifted;
                    end
                end
            end
            CSUM: begin
`ifdef DOUT_PACKER_CHECKSUM_EN
                if (!fifoFull) begin
                    fifoPush        = 1'b1;
                    pushEntry.value = acc_q;
                    pushEntry.keep  = 4'hF;
                    pushEntry.last  = 1'b1;
                    state_d         = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            lane_q  <= '0;
            rem_q   <= '0;
            pack_q  <= '0;
`ifdef DOUT_PACKER_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            pack_q  <= pack_d;
`ifdef DOUT_PACKER_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    packer_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (fifoPush),
        .wdata_i (pushEntry),
        .pop_i   (out_en),
        .head_o  (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign out_value = headEntry.value;
    assign out_keep  = headEntry.keep;
    assign out_last  = headEntry.last;
    assign out_rdy   = ~fifoEmpty;
    assign len_rdy   = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dout_packer.sv
// Scoreboard bench for dout_packer: expected words are queued when a frame starts,
// and a monitor compares every word the consumer pops.
module tb_dout_packer;

    logic        CLK;
    logic        RST;
    logic [7:0]  in_value;
    logic        in_rdy;
    logic        in_en;
    logic [7:0]  len_value;
    logic        len_en;
    logic        len_rdy;
    logic [31:0] out_value;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_rdy;
    logic        out_en;
    logic        busy;

    typedef struct {
        logic [31:0] v;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFail  = 0;

`ifdef DOUT_PACKER_CHECKSUM_EN
    logic expBusyAfterLast = 1'b1;
`else
    logic expBusyAfterLast = 1'b0;
`endif

    dout_packer #(.OUT_DEPTH(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_value  (in_value),
        .in_rdy    (in_rdy),
        .in_en     (in_en),
        .len_value (len_value),
        .len_en    (len_en),
        .len_rdy   (len_rdy),
        .out_value (out_value),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_rdy   (out_rdy),
        .out_en    (out_en),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: a pop happens on the next edge, so compare the head against the scoreboard now.
    always @(negedge CLK) begin
        if (!RST && out_rdy && out_en) begin
            nTests++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL unexpected_word: got %h/%h/%0d, required no word", out_value, out_keep, out_last);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (out_value !== e.v || out_keep !== e.k || out_last !== e.l) begin
                    nFail++;
                    $display("[TB] FAIL word: got value=%h keep=%h last=%0d, required value=%h keep=%h last=%0d",
                             out_value, out_keep, out_last, e.v, e.k, e.l);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic expWord(input logic [31:0] v, input logic [3:0] k, input logic l);
        exp_t e;
        e.v = v;
        e.k = k;
        e.l = l;
        expQ.push_back(e);
    endtask

    // Final data word of a frame, followed by the checksum word when that option is built in.
    task automatic expFinal(input logic [31:0] v, input logic [3:0] k, input logic [31:0] sum);
`ifdef DOUT_PACKER_CHECKSUM_EN
        expWord(v, k, 1'b0);
        expWord(sum, 4'hF, 1'b1);
`else
        expWord(v, k, 1'b1);
        if (sum == 32'hFFFF_FFFF) $display("[TB] note: unexpected sum argument");
`endif
    endtask

    task automatic startFrame(input logic [7:0] len);
        int c;
        c = 0;
        @(negedge CLK);
        while (!len_rdy && c < 1000) begin
            @(negedge CLK);
            c++;
        end
        if (!len_rdy) checkOutput("len_rdy_wait_timeout", {31'b0, len_rdy}, 32'd1);
        len_value = len;
        len_en    = 1'b1;
        @(posedge CLK);
        #1;
        len_en    = 1'b0;
    endtask

    // Offer one byte and hold it until the packer takes it on a rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        bit got;
        got      = 1'b0;
        in_value = b;
        in_rdy   = 1'b1;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge CLK);
            if (in_en === 1'b1) got = 1'b1;
            @(posedge CLK);
            #1;
        end
        if (!got) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic endStream();
        in_rdy = 1'b0;
    endtask

    // Wait for the frame to finish and the FIFO to empty, then confirm every expected word was seen.
    task automatic drain();
        int c;
        c = 0;
        @(negedge CLK);
        while ((out_rdy || busy) && c < 2000) begin
            @(negedge CLK);
            c++;
        end
        if (out_rdy || busy) checkOutput("drain_timeout", {30'b0, out_rdy, busy}, 32'd0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST       = 1'b1;
        in_value  = 8'h00;
        in_rdy    = 1'b1;
        len_value = 8'h00;
        len_en    = 1'b0;
        out_en    = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_in_en",     {31'b0, in_en},    32'd0);
        checkOutput("rst_len_rdy",   {31'b0, len_rdy},  32'd1);
        checkOutput("rst_out_rdy",   {31'b0, out_rdy},  32'd0);
        checkOutput("rst_out_value", out_value,         32'd0);
        checkOutput("rst_out_keep",  {28'b0, out_keep}, 32'd0);
        checkOutput("rst_out_last",  {31'b0, out_last}, 32'd0);
        checkOutput("rst_busy",      {31'b0, busy},     32'd0);
        @(posedge CLK);
        #1;
        RST    = 1'b0;
        in_rdy = 1'b0;

        // len=8, bytes 01..08 back-to-back
        expWord(32'h04030201, 4'hF, 1'b0);
        expFinal(32'h08070605, 4'hF, 32'h24);
        startFrame(8'd8);
        checkOutput("t1_busy_mid",    {31'b0, busy},    32'd1);
        checkOutput("t1_len_rdy_mid", {31'b0, len_rdy}, 32'd0);
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        endStream();
        checkOutput("t1_busy_after_last", {31'b0, busy}, {31'b0, expBusyAfterLast});
        drain();
        checkOutput("t1_len_rdy_idle", {31'b0, len_rdy}, 32'd1);

        // len=5 gives a partial final word
        expWord(32'hDDCCBBAA, 4'hF, 1'b0);
        expFinal(32'h000000EE, 4'h1, 32'h3FC);
        startFrame(8'd5);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        applyStimulus(8'hDD);
        applyStimulus(8'hEE);
        endStream();
        drain();

        // len=0 means 256 bytes; consumer stalled until the FIFO fills
        for (int k = 0; k < 64; k++) begin
            logic [31:0] w;
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            if (k < 63) expWord(w, 4'hF, 1'b0);
            else        expFinal(w, 4'hF, 32'h7F80);
        end
        out_en = 1'b0;
        startFrame(8'd0);
        for (int i = 0; i < 8; i++) applyStimulus(8'(i));
        in_value = 8'h08;
        in_rdy   = 1'b1;
        @(negedge CLK);
        checkOutput("t3_in_en_full",  {31'b0, in_en},   32'd0);
        checkOutput("t3_out_rdy_full", {31'b0, out_rdy}, 32'd1);
        @(posedge CLK);
        #1;
        out_en = 1'b1;
        for (int i = 8; i < 256; i++) applyStimulus(8'(i));
        endStream();
        drain();

        // Reset mid-frame discards the partial frame
        startFrame(8'd6);
        applyStimulus(8'h31);
        applyStimulus(8'h32);
        applyStimulus(8'h33);
        RST = 1'b1;
        #1;
        checkOutput("t4_out_rdy_rst", {31'b0, out_rdy}, 32'd0);
        checkOutput("t4_len_rdy_rst", {31'b0, len_rdy}, 32'd1);
        checkOutput("t4_busy_rst",    {31'b0, busy},    32'd0);
        checkOutput("t4_in_en_rst",   {31'b0, in_en},   32'd0);
        @(posedge CLK);
        #1;
        RST    = 1'b0;
        in_rdy = 1'b0;
        expFinal(32'h0000007F, 4'h1, 32'h7F);
        startFrame(8'd1);
        applyStimulus(8'h7F);
        endStream();
        drain();

        // len_en during an active frame is ignored
        expFinal(32'h44332211, 4'hF, 32'hAA);
        startFrame(8'd4);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        len_value = 8'd9;
        len_en    = 1'b1;
        applyStimulus(8'h33);
        len_en    = 1'b0;
        applyStimulus(8'h44);
        endStream();
        checkOutput("t5_busy_after_last", {31'b0, busy}, {31'b0, expBusyAfterLast});
        drain();
        checkOutput("t5_len_rdy_idle", {31'b0, len_rdy}, 32'd1);

        // len=3, bytes FF FF 02
        expFinal(32'h0002FFFF, 4'h7, 32'h200);
        startFrame(8'd3);
        applyStimulus(8'hFF);
        applyStimulus(8'hFF);
        applyStimulus(8'h02);
        endStream();
        drain();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
